// File: rtl/lane_block_striper_if.sv
// Bundles the stream-side and lane-side signals of lane_block_striper.
// Optional lane_rev exists only when LANE_BLOCK_REVERSAL_EN is defined.
interface lane_block_striper_if #(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 8
) ();
    logic                        enable_t;
    logic                        enable_r;
    logic                        tx_transport;
    logic [NUM_LANES*DATA_W-1:0] tx_in;
    logic                        tx_in_valid;
    logic [NUM_LANES*DATA_W-1:0] tx_lanes_out;
    logic                        tx_out_valid;
    logic                        tx_block_start;
    logic                        rx_transport;
    logic [NUM_LANES*DATA_W-1:0] rx_lanes_in;
    logic                        rx_in_valid;
    logic [NUM_LANES*DATA_W-1:0] rx_stream_out;
    logic                        rx_out_valid;
    logic                        rx_block_done;
`ifdef LANE_BLOCK_REVERSAL_EN
    logic                        lane_rev;
`endif

    modport master (
`ifdef LANE_BLOCK_REVERSAL_EN
        output lane_rev,
`endif
        output enable_t, enable_r, tx_transport, tx_in, tx_in_valid,
        output rx_transport, rx_lanes_in, rx_in_valid,
        input  tx_lanes_out, tx_out_valid, tx_block_start,
        input  rx_stream_out, rx_out_valid, rx_block_done
    );

    modport slave (
`ifdef LANE_BLOCK_REVERSAL_EN
        input  lane_rev,
`endif
        input  enable_t, enable_r, tx_transport, tx_in, tx_in_valid,
        input  rx_transport, rx_lanes_in, rx_in_valid,
        output tx_lanes_out, tx_out_valid, tx_block_start,
        output rx_stream_out, rx_out_valid, rx_block_done
    );
endinterface

// File: rtl/lane_block_striper.sv
// Ping-pong block transposer: stripes stream words onto lanes in GRAN-symbol blocks (TX)
// and merges lane columns back to stream order (RX). Lane reversal: LANE_BLOCK_REVERSAL_EN.
module lane_block_striper #(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 8,
    parameter int GRAN      = 4
) (
    input  logic               clk,
    input  logic               rst,
    lane_block_striper_if.slave bus
);
    localparam int N     = NUM_LANES;
    localparam int W     = DATA_W;
    localparam int NW    = N * W;
    localparam int BLK   = N * GRAN;
    localparam int CNT_W = (GRAN > 2) ? $clog2(GRAN) : 1;
    localparam int IDX_W = $clog2(BLK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(GRAN - 1);

    function automatic logic [NW-1:0] swap_lanes(input logic [NW-1:0] x);
        logic [NW-1:0] r;
        for (int p = 0; p < N; p++) r[p*W +: W] = x[(N-1-p)*W +: W];
        return r;
    endfunction

    logic lane_rev;
`ifdef LANE_BLOCK_REVERSAL_EN
    assign lane_rev = bus.lane_rev;
`else
    assign lane_rev = 1'b0;
`endif

    // ---------------- TX: stream words -> lane columns ----------------
    logic [W-1:0]     tx_buf_q [2][BLK];
    logic [CNT_W-1:0] tx_fill_q, tx_fill_d, tx_col_q, tx_col_d;
    logic             tx_sel_q, tx_sel_d, tx_drain_q, tx_drain_d, tx_rev_q, tx_rev_d;
    logic             tx_mode_q, tx_os_valid_q;
    logic [NW-1:0]    tx_os_q, tx_lanes;
    logic             tx_flip, tx_accept, tx_last;

    assign tx_flip   = bus.tx_transport != tx_mode_q;
    assign tx_accept = bus.tx_in_valid & bus.tx_transport & ~tx_flip;
    assign tx_last   = tx_accept && (tx_fill_q == LAST);

    always_comb begin
        tx_fill_d  = tx_fill_q;
        tx_col_d   = tx_col_q;
        tx_sel_d   = tx_sel_q;
        tx_drain_d = tx_drain_q;
        tx_rev_d   = tx_rev_q;
        if (tx_flip) begin
            tx_fill_d  = '0;
            tx_col_d   = '0;
            tx_drain_d = 1'b0;
        end else begin
            if (tx_accept) tx_fill_d = tx_last ? '0 : tx_fill_q + CNT_W'(1);
            // A completed fill restarts the drain even on the prior block's last column.
            if (tx_last) begin
                tx_sel_d   = ~tx_sel_q;
                tx_drain_d = 1'b1;
                tx_col_d   = '0;
                tx_rev_d   = lane_rev;
            end else if (tx_drain_q) begin
                if (tx_col_q == LAST) begin
                    tx_drain_d = 1'b0;
                    tx_col_d   = '0;
                end else begin
                    tx_col_d = tx_col_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.enable_t) begin
            tx_fill_q     <= '0;
            tx_col_q      <= '0;
            tx_sel_q      <= 1'b0;
            tx_drain_q    <= 1'b0;
            tx_rev_q      <= 1'b0;
            tx_mode_q     <= bus.tx_transport;
            tx_os_q       <= '0;
            tx_os_valid_q <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < BLK; k++) tx_buf_q[b][k] <= '0;
        end else begin
            tx_fill_q     <= tx_fill_d;
            tx_col_q      <= tx_col_d;
            tx_sel_q      <= tx_sel_d;
            tx_drain_q    <= tx_drain_d;
            tx_rev_q      <= tx_rev_d;
            tx_mode_q     <= bus.tx_transport;
            tx_os_valid_q <= bus.tx_in_valid & ~bus.tx_transport;
            tx_os_q       <= (bus.tx_in_valid & ~bus.tx_transport) ?
                             (lane_rev ? swap_lanes(bus.tx_in) : bus.tx_in) : '0;
            if (tx_accept)
                for (int j = 0; j < N; j++)
                    tx_buf_q[tx_sel_q][IDX_W'(int'(tx_fill_q) * N + j)] <= bus.tx_in[j*W +: W];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_tx_lane
        localparam logic [IDX_W-1:0] BASE_F = IDX_W'(gi * GRAN);
        localparam logic [IDX_W-1:0] BASE_R = IDX_W'((N - 1 - gi) * GRAN);
        logic [IDX_W-1:0] idx;
        assign idx = (tx_rev_q ? BASE_R : BASE_F) + IDX_W'(tx_col_q);
        assign tx_lanes[gi*W +: W] = tx_drain_q ? tx_buf_q[~tx_sel_q][idx] : tx_os_q[gi*W +: W];
    end

    assign bus.tx_lanes_out   = tx_lanes;
    assign bus.tx_out_valid   = tx_drain_q | tx_os_valid_q;
    assign bus.tx_block_start = tx_drain_q && (tx_col_q == '0);

    // ---------------- RX: lane columns -> stream words ----------------
    logic [W-1:0]     rx_buf_q [2][BLK];
    logic [CNT_W-1:0] rx_fill_q, rx_fill_d, rx_col_q, rx_col_d;
    logic             rx_sel_q, rx_sel_d, rx_drain_q, rx_drain_d, rx_rev_q, rx_rev_d;
    logic             rx_mode_q, rx_os_valid_q;
    logic [NW-1:0]    rx_os_q, rx_words;
    logic             rx_flip, rx_accept, rx_last, rx_rev_eff;

    assign rx_flip    = bus.rx_transport != rx_mode_q;
    assign rx_accept  = bus.rx_in_valid & bus.rx_transport & ~rx_flip;
    assign rx_last    = rx_accept && (rx_fill_q == LAST);
    // Lane order is taken from the first column and held for the rest of the block.
    assign rx_rev_eff = (rx_fill_q == '0) ? lane_rev : rx_rev_q;

    always_comb begin
        rx_fill_d  = rx_fill_q;
        rx_col_d   = rx_col_q;
        rx_sel_d   = rx_sel_q;
        rx_drain_d = rx_drain_q;
        rx_rev_d   = rx_rev_q;
        if (rx_flip) begin
            rx_fill_d  = '0;
            rx_col_d   = '0;
            rx_drain_d = 1'b0;
        end else begin
            if (rx_accept) begin
                rx_fill_d = rx_last ? '0 : rx_fill_q + CNT_W'(1);
                if (rx_fill_q == '0) rx_rev_d = lane_rev;
            end
            if (rx_last) begin
                rx_sel_d   = ~rx_sel_q;
                rx_drain_d = 1'b1;
                rx_col_d   = '0;
            end else if (rx_drain_q) begin
                if (rx_col_q == LAST) begin
                    rx_drain_d = 1'b0;
                    rx_col_d   = '0;
                end else begin
                    rx_col_d = rx_col_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.enable_r) begin
            rx_fill_q     <= '0;
            rx_col_q      <= '0;
            rx_sel_q      <= 1'b0;
            rx_drain_q    <= 1'b0;
            rx_rev_q      <= 1'b0;
            rx_mode_q     <= bus.rx_transport;
            rx_os_q       <= '0;
            rx_os_valid_q <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < BLK; k++) rx_buf_q[b][k] <= '0;
        end else begin
            rx_fill_q     <= rx_fill_d;
            rx_col_q      <= rx_col_d;
            rx_sel_q      <= rx_sel_d;
            rx_drain_q    <= rx_drain_d;
            rx_rev_q      <= rx_rev_d;
            rx_mode_q     <= bus.rx_transport;
            rx_os_valid_q <= bus.rx_in_valid & ~bus.rx_transport;
            rx_os_q       <= (bus.rx_in_valid & ~bus.rx_transport) ?
                             (lane_rev ? swap_lanes(bus.rx_lanes_in) : bus.rx_lanes_in) : '0;
            if (rx_accept)
                for (int p = 0; p < N; p++)
                    rx_buf_q[rx_sel_q][IDX_W'((rx_rev_eff ? (N - 1 - p) : p) * GRAN + int'(rx_fill_q))]
                        <= bus.rx_lanes_in[p*W +: W];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_rx_byte
        logic [IDX_W-1:0] idx;
        assign idx = IDX_W'(int'(rx_col_q) * N + gi);
        assign rx_words[gi*W +: W] = rx_drain_q ? rx_buf_q[~rx_sel_q][idx] : rx_os_q[gi*W +: W];
    end

    assign bus.rx_stream_out = rx_words;
    assign bus.rx_out_valid  = rx_drain_q | rx_os_valid_q;
    assign bus.rx_block_done = rx_last & ~rst & bus.enable_r;
endmodule

// File: tb/tb_lane_block_striper.sv
// Scoreboarded bench for lane_block_striper (N=2, W=8, GRAN=4); expectations carry the cycle
// in which each output beat must appear.
module tb_lane_block_striper;
    localparam int N = 2;
    localparam int W = 8;
    localparam int G = 4;

    typedef struct {
        logic [15:0] data;
        logic        start;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;
    logic exp_rx_done = 1'b0;

    beat_t tx_q[$];
    beat_t rx_q[$];
    logic [7:0] tx_bytes [N*G];
    logic [7:0] rx_bytes [N*G];
    int   m_tx_cnt = 0;
    int   m_rx_cnt = 0;
    logic rx_rev_lat = 1'b0;

    lane_block_striper_if #(.NUM_LANES(N), .DATA_W(W)) bus ();

    lane_block_striper #(.NUM_LANES(N), .DATA_W(W), .GRAN(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic cur_rev();
`ifdef LANE_BLOCK_REVERSAL_EN
        return bus.lane_rev;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] swap16(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
        exp_rx_done = 1'b0;
    endtask

    task automatic drive_tx(input logic v, input logic [15:0] d);
        logic [15:0] col;
        int l;
        next_cycle();
        bus.tx_in       = d;
        bus.tx_in_valid = v;
        if (v && bus.tx_transport) begin
            for (int j = 0; j < N; j++) tx_bytes[m_tx_cnt*N + j] = d[j*W +: W];
            m_tx_cnt++;
            if (m_tx_cnt == G) begin
                m_tx_cnt = 0;
                for (int c = 0; c < G; c++) begin
                    for (int p = 0; p < N; p++) begin
                        l = cur_rev() ? (N - 1 - p) : p;
                        col[p*W +: W] = tx_bytes[l*G + c];
                    end
                    tx_q.push_back('{col, (c == 0), cyc + 1 + c});
                end
            end
        end else if (v) begin
            tx_q.push_back('{(cur_rev() ? swap16(d) : d), 1'b0, cyc + 1});
        end
    endtask

    task automatic drive_rx(input logic v, input logic [15:0] d);
        logic [15:0] word;
        int l;
        next_cycle();
        bus.rx_lanes_in = d;
        bus.rx_in_valid = v;
        if (v && bus.rx_transport) begin
            if (m_rx_cnt == 0) rx_rev_lat = cur_rev();
            for (int p = 0; p < N; p++) begin
                l = rx_rev_lat ? (N - 1 - p) : p;
                rx_bytes[l*G + m_rx_cnt] = d[p*W +: W];
            end
            if (m_rx_cnt == G - 1) begin
                exp_rx_done = 1'b1;
                for (int w = 0; w < G; w++) begin
                    for (int j = 0; j < N; j++) word[j*W +: W] = rx_bytes[w*N + j];
                    rx_q.push_back('{word, 1'b0, cyc + 1 + w});
                end
            end
            m_rx_cnt = (m_rx_cnt + 1) % G;
        end else if (v) begin
            rx_q.push_back('{(cur_rev() ? swap16(d) : d), 1'b0, cyc + 1});
        end
    endtask

    task automatic set_tx_mode(input logic m);
        next_cycle();
        bus.tx_transport = m;
        bus.tx_in_valid  = 1'b0;
        m_tx_cnt = 0;
    endtask

    task automatic set_rx_mode(input logic m);
        next_cycle();
        bus.rx_transport = m;
        bus.rx_in_valid  = 1'b0;
        m_rx_cnt = 0;
    endtask

    task automatic set_rst(input logic v);
        next_cycle();
        rst = v;
        bus.tx_in_valid = 1'b0;
        bus.rx_in_valid = 1'b0;
        if (v) begin
            m_tx_cnt = 0;
            m_rx_cnt = 0;
            while (tx_q.size() > 0 && tx_q[$].cyc > cyc) void'(tx_q.pop_back());
            while (rx_q.size() > 0 && rx_q[$].cyc > cyc) void'(rx_q.pop_back());
        end
    endtask

    task automatic set_enr(input logic v);
        next_cycle();
        bus.enable_r    = v;
        bus.rx_in_valid = 1'b0;
        if (!v) begin
            m_rx_cnt = 0;
            while (rx_q.size() > 0 && rx_q[$].cyc > cyc) void'(rx_q.pop_back());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_tx(1'b0, 16'h0000);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (mon_en) begin
            if (bus.tx_out_valid === 1'b1) begin
                chk("tx_beat_expected", 64'(tx_q.size() > 0), 64'(1));
                if (tx_q.size() > 0) begin
                    e = tx_q.pop_front();
                    $display("tx beat cyc=%0d lanes=%h start=%b", cyc, bus.tx_lanes_out, bus.tx_block_start);
                    chk("tx_data", 64'(bus.tx_lanes_out), 64'(e.data));
                    chk("tx_block_start", 64'(bus.tx_block_start), 64'(e.start));
                    chk("tx_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("tx_valid_low", 64'(bus.tx_out_valid), 64'(0));
                chk("tx_idle_zero", 64'({bus.tx_lanes_out, bus.tx_block_start}), 64'(0));
            end
            if (bus.rx_out_valid === 1'b1) begin
                chk("rx_beat_expected", 64'(rx_q.size() > 0), 64'(1));
                if (rx_q.size() > 0) begin
                    e = rx_q.pop_front();
                    $display("rx beat cyc=%0d word=%h", cyc, bus.rx_stream_out);
                    chk("rx_data", 64'(bus.rx_stream_out), 64'(e.data));
                    chk("rx_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("rx_valid_low", 64'(bus.rx_out_valid), 64'(0));
                chk("rx_idle_zero", 64'(bus.rx_stream_out), 64'(0));
            end
            chk("rx_block_done", 64'(bus.rx_block_done), 64'(exp_rx_done));
        end
    end

    initial begin
        bus.enable_t     = 1'b1;
        bus.enable_r     = 1'b1;
        bus.tx_transport = 1'b1;
        bus.rx_transport = 1'b1;
        bus.tx_in        = '0;
        bus.tx_in_valid  = 1'b0;
        bus.rx_lanes_in  = '0;
        bus.rx_in_valid  = 1'b0;
`ifdef LANE_BLOCK_REVERSAL_EN
        bus.lane_rev     = 1'b0;
`endif
        next_cycle();
        mon_en = 1'b1;
        idle(2);
        set_rst(1'b0);
        idle(2);

        // Basic striping of one block
        drive_tx(1'b1, 16'h0100);
        drive_tx(1'b1, 16'h0302);
        drive_tx(1'b1, 16'h0504);
        drive_tx(1'b1, 16'h0706);
        idle(6);

        // Two back-to-back blocks, then a block with valid on every other cycle
        for (int i = 0; i < 2 * G; i++) drive_tx(1'b1, 16'($urandom));
        for (int i = 0; i < G; i++) begin
            drive_tx(1'b1, 16'($urandom));
            drive_tx(1'b0, 16'($urandom));
        end
        idle(6);

        // Partial block discarded by a switch to ordered sets and back
        drive_tx(1'b1, 16'h1111);
        drive_tx(1'b1, 16'h2222);
        set_tx_mode(1'b0);
        drive_tx(1'b1, 16'hA5C3);
        drive_tx(1'b0, 16'hFFFF);
        drive_tx(1'b1, 16'h5A3C);
        set_tx_mode(1'b1);
        drive_tx(1'b1, 16'h1110);
        drive_tx(1'b1, 16'h1312);
        drive_tx(1'b1, 16'h1514);
        drive_tx(1'b1, 16'h1716);
        idle(6);

        // Reset in the middle of a drain, then a fresh block
        for (int i = 0; i < G; i++) drive_tx(1'b1, 16'($urandom));
        drive_tx(1'b0, 16'h0000);
        set_rst(1'b1);
        set_rst(1'b0);
        for (int i = 0; i < G; i++) drive_tx(1'b1, 16'($urandom));
        idle(6);

        // RX merge, then a random block
        drive_rx(1'b1, 16'h0400);
        drive_rx(1'b1, 16'h0501);
        drive_rx(1'b1, 16'h0602);
        drive_rx(1'b1, 16'h0703);
        for (int i = 0; i < G; i++) drive_rx(1'b1, 16'($urandom));
        drive_rx(1'b0, 16'h0000);
        idle(5);

        // RX ordered-set pass-through
        set_rx_mode(1'b0);
        drive_rx(1'b1, 16'hA5C3);
        drive_rx(1'b0, 16'h1234);
        set_rx_mode(1'b1);
        idle(2);

        // RX enable dropped mid-fill, then a fresh block
        drive_rx(1'b1, 16'hDEAD);
        drive_rx(1'b1, 16'hBEEF);
        set_enr(1'b0);
        set_enr(1'b1);
        for (int i = 0; i < G; i++) drive_rx(1'b1, 16'($urandom));
        drive_rx(1'b0, 16'h0000);
        idle(6);

`ifdef LANE_BLOCK_REVERSAL_EN
        // Lane-reversed striping of the basic block
        bus.lane_rev = 1'b1;
        drive_tx(1'b1, 16'h0100);
        drive_tx(1'b1, 16'h0302);
        drive_tx(1'b1, 16'h0504);
        drive_tx(1'b1, 16'h0706);
        idle(6);
        bus.lane_rev = 1'b0;
        idle(2);
`endif

        idle(4);
        chk("tx_queue_drained", 64'(tx_q.size()), 64'(0));
        chk("rx_queue_drained", 64'(rx_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
